// File: rtl/sort_stream.sv
// sort_stream: loads up to DEPTH unsigned words, sorts them in place with an
// odd-even transposition network (one phase per clock), then streams them out
// in ascending or descending order under ready/valid handshakes.
module sort_stream #(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 64,
    parameter int CNTW      = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [CNTW-1:0]      n,
    input  logic                 desc,
    input  logic                 in_valid,
    input  logic [DATAWIDTH-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [DATAWIDTH-1:0] out_data,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] ONE_C   = CNTW'(1);
    localparam logic [CNTW-1:0] ZERO_C  = CNTW'(0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SORT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNTW-1:0]        n_q, n_d;
    logic                   desc_q, desc_d;
    logic [CNTW-1:0]        idx_q, idx_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [DATAWIDTH-1:0]   mem_q [DEPTH];
    logic [DATAWIDTH-1:0]   mem_d [DEPTH];
    logic                   last_s;

    // True when the pair (a,b) must be exchanged; equal words never swap.
    function automatic logic out_of_order(input logic [DATAWIDTH-1:0] a,
                                          input logic [DATAWIDTH-1:0] b,
                                          input logic                 dsc);
        if (dsc) begin
            return (a < b);
        end else begin
            return (a > b);
        end
    endfunction

    // The shared index has reached the final word/phase of the latched job.
    assign last_s = (idx_q == (n_q - ONE_C));

    // Outputs decoded from registered state only; out_data forced to 0 when idle.
    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = (state_q == S_OUT) ? mem_q[idx_q[AW-1:0]] : '0;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;

    // Next-state logic: job control, shared load/phase/output index, pulses.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        desc_d  = desc_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    if ((n != ZERO_C) && (n <= DEPTH_C)) begin
                        n_d     = n;
                        desc_d  = desc;
                        idx_d   = ZERO_C;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (last_s) begin
                        idx_d   = ZERO_C;
                        state_d = S_SORT;
                    end else begin
                        idx_d = idx_q + ONE_C;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            S_SORT: begin
                // idx_q counts the phase; exactly n phases are run.
                if (last_s) begin
                    idx_d   = ZERO_C;
                    state_d = S_OUT;
                end else begin
                    idx_d = idx_q + ONE_C;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (last_s) begin
                        idx_d   = ZERO_C;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + ONE_C;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = ZERO_C;
            end
        endcase
    end

    // Storage update: load writes, or one odd-even transposition phase in SORT.
    always_comb begin
        mem_d = mem_q;
        if ((state_q == S_LOAD) && in_valid) begin
            mem_d[idx_q[AW-1:0]] = in_data;
        end else if (state_q == S_SORT) begin
            // Pairs in one phase are disjoint, so reading mem_q is sufficient.
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (((i % 2) == int'(idx_q[0])) && (CNTW'(i + 1) < n_q)) begin
                    if (out_of_order(mem_q[i], mem_q[i+1], desc_q)) begin
                        mem_d[i]   = mem_q[i+1];
                        mem_d[i+1] = mem_q[i];
                    end else begin
                        mem_d[i]   = mem_q[i];
                        mem_d[i+1] = mem_q[i+1];
                    end
                end else begin
                    mem_d[i] = mem_d[i];
                end
            end
        end else begin
            mem_d = mem_q;
        end
    end

    // State, control and storage registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            n_q     <= ZERO_C;
            desc_q  <= 1'b0;
            idx_q   <= ZERO_C;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            desc_q  <= desc_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sort_stream.sv
// Directed testbench for sort_stream with a scoreboard of expected outputs.
module tb_sort_stream;

    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int CNTW  = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic            go;
    logic [CNTW-1:0] n;
    logic            desc;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_ready;
    logic            busy;
    logic            done;
    logic            err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] stim [DEPTH];
    logic [DW-1:0] exp_q [$];

    sort_stream #(.DATAWIDTH(DW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .go(go), .n(n), .desc(desc),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one job from stim[0..nn-1]; expected outputs must already be queued.
    task automatic run_job(input int nn, input logic d, input bit toggle, input bit go_in_sort);
        int lat;
        int xfers;
        bit got;
        bit prev_stall;
        logic [DW-1:0] prev_data;
        logic [DW-1:0] e;
        go = 1'b1; n = CNTW'(nn); desc = d;
        tick();
        go = 1'b0; n = CNTW'(3); desc = ~d;
        check("busy_after_go", 32'(busy), 32'(1));
        check("in_ready_load", 32'(in_ready), 32'(1));
        for (int k = 0; k < nn; k++) begin
            in_valid = 1'b1; in_data = stim[k];
            tick();
        end
        in_valid = 1'b0; in_data = '0;
        lat = 1; got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            if (out_valid) begin
                got = 1'b1;
            end else begin
                check("in_ready_sort", 32'(in_ready), 32'(0));
                check("out_data_zero", 32'(out_data), 32'(0));
                check("err_sort", 32'(err), 32'(0));
                go = go_in_sort && (c == 1);
                tick();
                lat++;
            end
        end
        go = 1'b0;
        check("out_valid_seen", 32'(got), 32'(1));
        check("latency", 32'(lat), 32'(nn + 1));
        xfers = 0; prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 1000 && xfers < nn; c++) begin
            out_ready = toggle ? ((c % 2) == 0) : 1'b1;
            check("out_valid_hold", 32'(out_valid), 32'(1));
            check("done_low", 32'(done), 32'(0));
            if (prev_stall) check("stall_stable", 32'(out_data), 32'(prev_data));
            if (out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                check("out_data", 32'(out_data), 32'(e));
                xfers++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                prev_data  = out_data;
            end
            tick();
        end
        out_ready = 1'b1;
        check("xfers", 32'(xfers), 32'(nn));
        check("done_pulse", 32'(done), 32'(1));
        check("busy_low_at_done", 32'(busy), 32'(0));
        check("out_valid_after", 32'(out_valid), 32'(0));
        check("out_data_after", 32'(out_data), 32'(0));
        tick();
        check("done_once", 32'(done), 32'(0));
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic bad_go(input int nn, input string tag);
        go = 1'b1; n = CNTW'(nn); desc = 1'b0;
        tick();
        go = 1'b0;
        check({tag, "_err"}, 32'(err), 32'(1));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_in_ready"}, 32'(in_ready), 32'(0));
        tick();
        check({tag, "_err_clear"}, 32'(err), 32'(0));
        check({tag, "_busy2"}, 32'(busy), 32'(0));
    endtask

    initial begin
        rst = 1'b0; go = 1'b0; n = '0; desc = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        tick(); tick();
        rst = 1'b1;
        tick();

        // Ascending n=8
        stim[0]=8'd5; stim[1]=8'd3; stim[2]=8'd8; stim[3]=8'd1;
        stim[4]=8'd9; stim[5]=8'd2; stim[6]=8'd7; stim[7]=8'd4;
        exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd7, 8'd8, 8'd9};
        run_job(8, 1'b0, 1'b0, 1'b0);

        // Descending n=8, same input
        exp_q = '{8'd9, 8'd8, 8'd7, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        run_job(8, 1'b1, 1'b0, 1'b0);

        // Full depth, reversed input, consumer stalls every other cycle
        for (int k = 0; k < DEPTH; k++) begin
            stim[k] = DW'(DEPTH - 1 - k);
            exp_q.push_back(DW'(k));
        end
        run_job(DEPTH, 1'b0, 1'b1, 1'b0);

        // Rejected job requests
        bad_go(0, "n0");
        bad_go(DEPTH + 1, "n65");

        // Duplicates and extremes, with go pulsed during SORT
        stim[0]=8'd7; stim[1]=8'd7; stim[2]=8'd0; stim[3]=8'd255;
        exp_q = '{8'd0, 8'd7, 8'd7, 8'd255};
        run_job(4, 1'b0, 1'b0, 1'b1);
        check("no_job_after_ignored_go", 32'(busy), 32'(0));

        // Single word still passes through one sort phase
        stim[0] = 8'd42;
        exp_q = '{8'd42};
        run_job(1, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of SORT aborts the job
        for (int k = 0; k < 16; k++) stim[k] = DW'(16 - k);
        go = 1'b1; n = CNTW'(16); desc = 1'b0;
        tick();
        go = 1'b0;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; in_data = stim[k];
            tick();
        end
        in_valid = 1'b0; in_data = '0;
        tick(); tick();
        check("pre_rst_busy", 32'(busy), 32'(1));
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_in_ready", 32'(in_ready), 32'(0));
        check("mid_rst_out_valid", 32'(out_valid), 32'(0));
        check("mid_rst_out_data", 32'(out_data), 32'(0));
        check("mid_rst_done", 32'(done), 32'(0));
        check("mid_rst_err", 32'(err), 32'(0));
        tick(); tick();
        rst = 1'b1;
        check("post_rst_done", 32'(done), 32'(0));
        tick();
        check("post_rst_done2", 32'(done), 32'(0));
        check("post_rst_busy", 32'(busy), 32'(0));

        stim[0] = 8'd2; stim[1] = 8'd1;
        exp_q = '{8'd1, 8'd2};
        run_job(2, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sort_stream.md
SORT_STREAM -- requirements
Module: sort_stream

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, width of each unsigned data word.
REQ-002 SHALL have parameter DEPTH, default 64, maximum words per sort job.
REQ-003 SHALL have parameter CNTW, default 9, width of count port n; DEPTH <= 2**CNTW-1.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port go  input  1  job start request, sampled in IDLE only.
REQ-007 SHALL have port n  input  CNTW  job word count, latched with go.
REQ-008 SHALL have port desc  input  1  order select, latched with go; 0 ascending, 1 descending.
REQ-009 SHALL have port in_valid  input  1  input word valid.
REQ-010 SHALL have port in_data  input  DATAWIDTH  input word.
REQ-011 SHALL have port in_ready  output  1  block accepts input word.
REQ-012 SHALL have port out_valid  output  1  sorted word valid.
REQ-013 SHALL have port out_data  output  DATAWIDTH  sorted word.
REQ-014 SHALL have port out_ready  input  1  consumer accepts sorted word.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse after last sorted word transfers.
REQ-017 SHALL have port err  output  1  one-cycle pulse on rejected go.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, SORT, OUT; storage is DEPTH registers of DATAWIDTH bits.
REQ-019 IDLE: go=1 with 1 <= n <= DEPTH SHALL latch n and desc, clear load index, move to LOAD next cycle.
REQ-020 IDLE: go=1 with n=0 or n>DEPTH SHALL pulse err the next cycle and remain in IDLE.
REQ-021 go SHALL be ignored outside IDLE; latched n/desc SHALL not change mid-job.
REQ-022 LOAD: in_ready=1; a transfer (in_valid & in_ready) SHALL write in_data to entry[index], index+1.
REQ-023 LOAD: the cycle of the n-th transfer SHALL move to SORT; in_ready SHALL be 0 in all other states.
REQ-024 SORT SHALL perform odd-even transposition: phase k (k=0..n-1) compare-swaps all pairs (i,i+1) with i%2 == k%2 and i+1 < n, in parallel, one phase per cycle.
REQ-025 SORT SHALL last exactly n cycles, then move to OUT; entries at index >= n SHALL never be touched.
REQ-026 Compare SHALL be unsigned; swap only when strictly out of order (desc=0: a>b; desc=1: a<b); equal words never swap.
REQ-027 OUT: out_valid=1, out_data=entry[out index] starting at 0; transfer (out_valid & out_ready) SHALL advance index.
REQ-028 OUT: out_data SHALL hold stable while out_valid & !out_ready.
REQ-029 OUT: the cycle of the n-th transfer SHALL move to IDLE and assert done for the following cycle only.
REQ-030 n=1 SHALL still pass through SORT for 1 cycle with no swap.
REQ-031 Latency from last input transfer to first out_valid SHALL be n+1 cycles.
REQ-032 busy SHALL go high the cycle after an accepted go and low the cycle done is high.
REQ-033 out_data SHALL be 0 whenever out_valid is 0.

Reset
REQ-034 rst=0 SHALL immediately force IDLE; in_ready, out_valid, out_data, busy, done, err all 0; indices and latched n/desc 0.
REQ-035 Storage entries SHALL be cleared to 0 on reset.
REQ-036 Reset asserted mid-LOAD, SORT or OUT SHALL abort the job with no done pulse; a new go after release SHALL start cleanly.

Verification
REQ-037 n=8, desc=0, input 5,3,8,1,9,2,7,4, out_ready=1 -> output 1,2,3,4,5,7,8,9; first out_valid 9 cycles after last input; done one cycle after last output.
REQ-038 n=8, desc=1, same input -> output 9,8,7,5,4,3,2,1.
REQ-039 n=DEPTH=64, input 63 down to 0, desc=0, out_ready toggled 1/0 each cycle -> output 0..63, out_data stable during stalls, 64 transfers, one done.
REQ-040 go with n=0, then go with n=65 -> err pulses each time, busy stays 0, in_ready stays 0.
REQ-041 n=4, input 7,7,0,255, desc=0; go pulsed during SORT -> output 0,7,7,255, go ignored, no err.
REQ-042 n=16 job, rst=0 asserted in SORT for 2 cycles -> all outputs 0 immediately, no done; then n=2 job with 2,1 -> output 1,2.
